// File: rtl/velocity_lcd_pkg.sv
// Shared state encoding, LCD byte constants and the BCD-digit-to-ASCII helper
// for the velocity LCD writer.
package velocity_lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CONVERT,
    SEND_ADDR,
    SEND_CHAR,
    DONE
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_MINUS   = 8'h2D;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam int NUM_CHARS  = 6;
  localparam int BCD_DIGITS = 5;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin16_to_bcd_seq.sv
// Sequential double-dabble: 16-bit binary to five BCD digits, one bit per cycle.
// done pulses 17 cycles after an accepted start; start is ignored while converting.
module bin16_to_bcd_seq
  import velocity_lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] shreg;
  logic [19:0] acc;
  logic [19:0] adj;
  logic [4:0]  cnt;
  logic        running;

  // Add-3 to every digit that would reach 10 or more after the next shift.
  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= 5'd0;
      shreg   <= 16'h0000;
      acc     <= 20'h00000;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (running) begin
        acc   <= {adj[18:0], shreg[15]};
        shreg <= {shreg[14:0], 1'b0};
        cnt   <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end else if (start) begin
        running <= 1'b1;
        cnt     <= 5'd16;
        shreg   <= bin;
        acc     <= 20'h00000;
      end
    end
  end

  // acc holds the result from done until the next accepted start.
  assign bcd = acc;

endmodule

// File: rtl/velocity_lcd_writer.sv
// Periodically captures signed velocity and writes sign + five digits to one LCD line.
// One byte per req/ack handshake; a frame waits indefinitely on lcd_ack, ticks during a frame queue one frame.
module velocity_lcd_writer
  import velocity_lcd_pkg::*;
#(
  parameter int         REFRESH_CYCLES = 2500000,
  parameter logic [7:0] LINE_ADDR      = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] val,
  output logic        lcd_req,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data,
  input  logic        lcd_ack,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_CYCLES);

  state_t      state;
  logic [CW-1:0] refresh_cnt;
  logic        tick;
  logic        pending;
  logic        start_frame;
  logic        sign;
  logic [15:0] mag;
  logic        conv_start;
  logic        conv_done;
  logic [19:0] bcd;
  logic [2:0]  idx;
  logic [7:0]  char_byte;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      refresh_cnt <= '0;
    end else if (refresh_cnt == CW'(REFRESH_CYCLES - 1)) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  assign tick        = enable && (refresh_cnt == CW'(REFRESH_CYCLES - 1));
  assign start_frame = enable && (tick || pending);

  always_comb begin
    case (idx)
      3'd1:    char_byte = digit_char(bcd[19:16]);
      3'd2:    char_byte = digit_char(bcd[15:12]);
      3'd3:    char_byte = digit_char(bcd[11:8]);
      3'd4:    char_byte = digit_char(bcd[7:4]);
      3'd5:    char_byte = digit_char(bcd[3:0]);
      default: char_byte = sign ? ASCII_MINUS : ASCII_SPACE;
    endcase
  end

  bin16_to_bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      lcd_req    <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      conv_start <= 1'b0;
      sign       <= 1'b0;
      mag        <= 16'h0000;
      idx        <= 3'd0;
    end else begin
      conv_start <= 1'b0;
      frame_done <= 1'b0;

      // A tick that lands on the very cycle a queued frame launches stays queued.
      if (!enable) begin
        pending <= 1'b0;
      end else if ((state == IDLE || state == DONE) && (tick || pending)) begin
        pending <= pending && tick;
      end else if (tick && state != IDLE) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_frame) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          sign       <= val[15];
          mag        <= val[15] ? (~val + 16'd1) : val;
          conv_start <= 1'b1;
          state      <= CONVERT;
        end
        CONVERT: begin
          if (conv_done) begin
            lcd_req  <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_data <= CMD_SET_DDRAM | LINE_ADDR;
            state    <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          if (lcd_ack) begin
            lcd_req <= 1'b0;
            idx     <= 3'd0;
            state   <= SEND_CHAR;
          end
        end
        SEND_CHAR: begin
          // req low here means the previous byte was just acked: this is the idle gap cycle.
          if (!lcd_req) begin
            lcd_req  <= 1'b1;
            lcd_rs   <= 1'b1;
            lcd_data <= char_byte;
          end else if (lcd_ack) begin
            lcd_req <= 1'b0;
            if (idx == 3'(NUM_CHARS - 1)) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        DONE: begin
          if (start_frame) begin
            state <= CAPTURE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_velocity_lcd_writer.sv
// Bench for velocity_lcd_writer: randomized values and ack timing, frames checked
// against an arithmetic model of the six-character line.
module tb_velocity_lcd_writer;

  localparam int R = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] val = 16'h0000;
  logic        lcd_ack = 1'b0;
  logic        lcd_req;
  logic        lcd_rs;
  logic [7:0]  lcd_data;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  velocity_lcd_writer #(.REFRESH_CYCLES(R), .LINE_ADDR(8'h40)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .val        (val),
    .lcd_req    (lcd_req),
    .lcd_rs     (lcd_rs),
    .lcd_data   (lcd_data),
    .lcd_ack    (lcd_ack),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // LCD driver model: ack after a random delay, optional stray acks while idle.
  int ack_lo = 2;
  int ack_hi = 2;
  bit spur_en = 1'b0;
  int wait_n = 0;
  int cur_delay = 0;

  initial forever begin
    @(posedge clk);
    #1;
    lcd_ack = 1'b0;
    if (lcd_req && !rst) begin
      if (wait_n == 0) cur_delay = int'($urandom_range(ack_hi, ack_lo));
      if (wait_n >= cur_delay) begin
        lcd_ack = 1'b1;
        wait_n  = 0;
      end else begin
        wait_n++;
      end
    end else begin
      wait_n = 0;
      if (spur_en && $urandom_range(0, 7) == 0) lcd_ack = 1'b1;
    end
  end

  // Monitor and reference model.
  logic [8:0]  got_q[$];
  logic [15:0] fval_q[$];
  logic        p_req = 1'b0, p_busy = 1'b0, p_fd = 1'b0, p_acc = 1'b0, p_rs = 1'b0;
  logic [7:0]  p_data = 8'h00;

  task automatic check_frame();
    logic [15:0] v;
    int          mag;
    int          pw;
    logic [8:0]  exp_q[$];
    check("frame_len", 32'(got_q.size()), 32'd7);
    check("fd_busy", 32'(busy), 32'd1);
    check("frame_start_seen", 32'(fval_q.size()), 32'd1);
    if (fval_q.size() == 0) begin
      got_q.delete();
      return;
    end
    v   = fval_q.pop_front();
    mag = int'($signed(v));
    exp_q.push_back({1'b0, 8'hC0});
    exp_q.push_back({1'b1, (mag < 0) ? 8'h2D : 8'h20});
    if (mag < 0) mag = -mag;
    pw = 10000;
    for (int d = 0; d < 5; d++) begin
      exp_q.push_back({1'b1, 8'(32'h30 + (mag / pw) % 10)});
      pw = pw / 10;
    end
    for (int i = 0; i < 7; i++) begin
      check($sformatf("val%0h_byte%0d", v, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
    end
    got_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      p_req = 1'b0; p_busy = 1'b0; p_fd = 1'b0; p_acc = 1'b0;
      got_q.delete();
      fval_q.delete();
    end else begin
      if (busy && (!p_busy || p_fd)) fval_q.push_back(val);
      if (p_acc) check("req_gap", 32'(lcd_req), 32'd0);
      if (lcd_req && p_req && !p_acc) begin
        check("rs_stable", 32'(lcd_rs), 32'(p_rs));
        check("data_stable", 32'(lcd_data), 32'(p_data));
      end
      if (p_fd) check("fd_pulse", 32'(frame_done), 32'd0);
      if (lcd_req && lcd_ack) got_q.push_back({lcd_rs, lcd_data});
      if (frame_done) check_frame();
      p_req  = lcd_req;
      p_rs   = lcd_rs;
      p_data = lcd_data;
      p_busy = busy;
      p_fd   = frame_done;
      p_acc  = lcd_req && lcd_ack;
    end
  end

  task automatic wait_fd(input string tag, input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < bound);
    check(tag, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_char3(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(got_q.size() == 3 && lcd_req) && n < 400);
    check(tag, 32'(lcd_req), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] vals [6] = '{16'd1234, 16'hFFF9, 16'h8000, 16'h7FFF, 16'd0, 16'd9};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(lcd_req), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_data", 32'(lcd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);

    // Single frames over corner and random values, quick acks with stray acks.
    @(posedge clk);
    #1;
    rst = 1'b0;
    enable = 1'b1;
    spur_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      val = (i < 6) ? vals[i] : 16'($urandom);
      wait_fd("frame_done", 300);
      @(negedge clk);
      check("idle_after_frame", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end

    // Reset while the third character waits for its ack.
    spur_en = 1'b0;
    val = 16'd4321;
    wait_char3("reach_char3");
    @(posedge clk);
    #1;
    rst = 1'b1;
    val = 16'd100;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_req", 32'(lcd_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fd", 32'(frame_done), 32'd0);
    check("mid_rst_rs", 32'(lcd_rs), 32'd0);
    check("mid_rst_data", 32'(lcd_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    while (n < 3 * R) begin
      @(negedge clk);
      if (busy) break;
      n++;
    end
    check("rst_to_frame_cycles", 32'(n), 32'(R));

    // val changes during conversion must not reach the line.
    repeat (5) @(posedge clk);
    #1;
    val = 16'd200;
    wait_fd("fd_val_hold", 300);

    // Drop enable mid-frame: this frame finishes, nothing follows.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 3 * R);
    wait_char3("reach_char3_en");
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_fd("fd_after_disable", 300);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (lcd_req || busy) n++;
    end
    check("quiet_after_disable", 32'(n), 32'd0);

    // Slow driver: ticks queue during frames, frames run back to back.
    @(posedge clk);
    #1;
    ack_lo = 100;
    ack_hi = 100;
    val = 16'($urandom);
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_fd("fd_b2b", 1500);
      @(negedge clk);
      check("b2b_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      val = 16'($urandom);
    end
    enable = 1'b0;
    wait_fd("fd_b2b_last", 1500);
    @(negedge clk);
    check("idle_after_b2b", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
